// File: rtl/gate_arb_pkg.sv
// Shared types and helpers for the gate-evaluation arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_arb_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_t;

  localparam int OPND_W = 4;
  localparam int STAT_W = 16;

  // Round-robin successor: the pointer moves to the slot after the winner, wrapping at n.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/gate_eval_stage.sv
// Registered 4-input gate evaluation: out1 = ~((in1&in2)|in3) | (in3&in4), out2 = in3&in4.
// Latency: 1 cycle from load to registered result.
// Backpressure: none; result holds until the next load.
module gate_eval_stage
  import gate_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OPND_W-1:0] opnd,
  output logic              out1,
  output logic              out2
);

  logic out1_q, out1_d;
  logic out2_q, out2_d;

  // Evaluate the gate network on load, otherwise hold the previous result.
  always_comb begin
    out1_d = out1_q;
    out2_d = out2_q;
    if (load) begin
      out2_d = opnd[2] & opnd[3];
      out1_d = ~((opnd[0] & opnd[1]) | opnd[2]) | out2_d;
    end
  end

  // Result register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_q <= 1'b0;
      out2_q <= 1'b0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign out1 = out1_q;
  assign out2 = out2_q;

endmodule

// File: rtl/gate_eval_arbiter.sv
// Round-robin scheduler sharing one registered gate-eval stage among NUM_REQ requesters; GATE_ARB_STATS_EN adds grant/stall counters.
// Latency: transfer edge -> EVAL -> RESP, rsp_valid high after the second edge; one transaction in flight.
// Backpressure: RESP holds id/results until rsp_ready; req_ready stays 0 outside IDLE.
module gate_eval_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OPND_W*NUM_REQ-1:0] req_in,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_out1,
  output logic                      rsp_out2,
  output logic                      busy
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic              xfer;
  logic [OPND_W-1:0] req_opnd [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_opnd
    assign req_opnd[g] = req_in[g*OPND_W +: OPND_W];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!gnt_vld && req_valid[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // FSM next state, grant, operand/id capture and pointer advance.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    opnd_d    = opnd_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          state_d  = EVAL;
          id_d     = gnt_idx;
          opnd_d   = req_opnd[gnt_idx];
          rr_ptr_d = ID_W'(next_rr(32'(gnt_idx), NUM_REQ));
        end
      end
      EVAL: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      opnd_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      opnd_q   <= opnd_d;
    end
  end

  assign xfer = |(req_valid & req_ready);

  gate_eval_stage u_stage (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == EVAL),
    .opnd (opnd_q),
    .out1 (rsp_out1),
    .out2 (rsp_out2)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

`ifdef GATE_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
  logic [STAT_W-1:0] grant_cnt_d [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-requester grant counters and RESP stall counter.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (xfer && gnt_idx == ID_W'(i) && grant_cnt_q[i] != '1)
        grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (state_q == RESP && !rsp_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt_q[g];
  end
  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Self-checking bench for gate_eval_arbiter: vector table, directed corner sequences, random vs reference model.
// Latency: n/a.
// Backpressure: exercised via rsp_ready stalls.
module tb_gate_eval_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_in;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic            rsp_out1;
  logic            rsp_out2;
  logic            busy;
`ifdef GATE_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_eval_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out1  (rsp_out1),
    .rsp_out2  (rsp_out2),
    .busy      (busy)
`ifdef GATE_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct {
    logic [3:0] opnd;
    int         req;
    logic       e1;
    logic       e2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_in    = '0;
    rsp_ready = 1'b0;
    #2;
    step();
    rst = 1'b0;
  endtask

  // Boolean definition of the gate network; returns {out1, out2}.
  function automatic logic [1:0] gate_ref(input logic [3:0] n);
    logic a, b, c, d, o1, o2;
    a = n[0]; b = n[1]; c = n[2]; d = n[3];
    o2 = c && d;
    o1 = !((a && b) || c) || o2;
    return {o1, o2};
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  // Reference model state for the random phase.
  int         m_ptr, m_pend, m_cyc, m_id, winner, jj, n, stall_left, done;
  logic       m_o1, m_o2;
  logic [N-1:0] exp_ready, onehot;
  logic [1:0] ro;
  int         gid[5];
  int         gcyc[5];
  logic [IW-1:0] hold_id;
  logic       hold_o1, hold_o2;

  initial begin
    vecs[0] = '{4'h3, 0, 1'b0, 1'b0};
    vecs[1] = '{4'hC, 2, 1'b1, 1'b1};
    vecs[2] = '{4'h0, 2, 1'b1, 1'b0};
    vecs[3] = '{4'h7, 2, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 1, 1'b1, 1'b1};
    vecs[5] = '{4'h8, 3, 1'b1, 1'b0};
    vecs[6] = '{4'h4, 3, 1'b0, 1'b0};
    vecs[7] = '{4'hB, 1, 1'b0, 1'b0};

    // Reset state, with requests asserted to show ready stays low in reset.
    req_valid = '1;
    req_in    = '0;
    rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_out1", rsp_out1, 0);
    chk("rst_out2", rsp_out2, 0);

    // Table: single request, 2-edge latency, gate function.
    for (int k = 0; k < 8; k++) begin
      do_reset();
      req_in = '0;
      req_in[4*vecs[k].req +: 4] = vecs[k].opnd;
      req_valid = '0;
      req_valid[vecs[k].req] = 1'b1;
      onehot = '0;
      onehot[vecs[k].req] = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", k), req_ready, onehot);
      step();
      req_valid = '0;
      chk($sformatf("v%0d_eval_busy", k), busy, 1);
      chk($sformatf("v%0d_eval_rv", k), rsp_valid, 0);
      step();
      chk($sformatf("v%0d_rv", k), rsp_valid, 1);
      chk($sformatf("v%0d_id", k), rsp_id, vecs[k].req);
      chk($sformatf("v%0d_out1", k), rsp_out1, vecs[k].e1);
      chk($sformatf("v%0d_out2", k), rsp_out2, vecs[k].e2);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_idle", k), busy, 0);
    end

    // All requesters valid: order 0,1,2,3,0 every 3 cycles.
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("t3_onehot", $countones(req_ready), 1);
        gid[n]  = first_set(req_ready);
        gcyc[n] = c;
        n++;
      end
      step();
    end
    chk("t3_grants", n, 5);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("t3_order%0d", k), gid[k], k % 4);
      if (k > 0) chk($sformatf("t3_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
    end

    // Backpressure: 5 stalled RESP cycles hold everything.
    do_reset();
    req_in[7:4] = 4'hC;
    req_valid   = 4'b0010;
    #1;
    step();
    step();
    req_valid = '1;
    hold_id = rsp_id;
    hold_o1 = rsp_out1;
    hold_o2 = rsp_out2;
    chk("t4_id", hold_id, 1);
    chk("t4_o1", hold_o1, 1);
    chk("t4_o2", hold_o2, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_rv%0d", k), rsp_valid, 1);
      chk($sformatf("t4_busy%0d", k), busy, 1);
      chk($sformatf("t4_rdy%0d", k), req_ready, 0);
      chk($sformatf("t4_hold%0d", k), {rsp_id, rsp_out1, rsp_out2}, {hold_id, hold_o1, hold_o2});
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_rv", rsp_valid, 0);
    req_valid = '0;

    // Async reset in EVAL: drop transaction, pointer back to 0.
    do_reset();
    req_in[11:8] = 4'hC;
    req_valid    = 4'b0100;
    rsp_ready    = 1'b1;
    #1;
    step();
    chk("t5_in_eval", busy, 1);
    req_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rv", rsp_valid, 0);
    chk("t5_rst_rdy", req_ready, 0);
    chk("t5_rst_outs", {rsp_id, rsp_out1, rsp_out2}, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t5_norsp%0d", k), {rsp_valid, busy}, 0);
      step();
    end
    req_valid = '1;
    #1;
    chk("t5_next_grant", req_ready, 4'b0001);
    req_valid = '0;

`ifdef GATE_ARB_STATS_EN
    // Statistics: 8 grants with 2 stall cycles.
    do_reset();
    req_valid  = '1;
    stall_left = 2;
    n = 0;
    done = 0;
    for (int c = 0; c < 100 && done == 0; c++) begin
      rsp_ready = 1'b1;
      if (rsp_valid && stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (req_ready != '0) n++;
      if (n == 8 && rsp_valid && rsp_ready) done = 1;
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("t6_done", done, 1);
    for (int k = 0; k < N; k++) chk($sformatf("t6_grants%0d", k), stat_grants[k*16 +: 16], 2);
    chk("t6_stall", stat_stall, 2);
`endif

    // Random traffic against the reference model.
    do_reset();
    m_ptr = 0; m_pend = 0; m_cyc = 0; m_id = 0; m_o1 = 0; m_o2 = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req_valid = '0;
      req_in    = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0;
      winner = -1;
      if (m_pend == 0) begin
        for (int i = 0; i < N; i++) begin
          jj = (m_ptr + i) % N;
          if (winner < 0 && req_valid[jj]) winner = jj;
        end
      end
      if (winner >= 0) exp_ready[winner] = 1'b1;
      chk($sformatf("r%0d_ready", c), req_ready, exp_ready);
      chk($sformatf("r%0d_busy", c), busy, (m_pend != 0));
      chk($sformatf("r%0d_rv", c), rsp_valid, (m_pend != 0 && m_cyc >= 2));
      if (m_pend != 0 && m_cyc >= 2)
        chk($sformatf("r%0d_rsp", c), {rsp_id, rsp_out1, rsp_out2}, {IW'(m_id), m_o1, m_o2});
      if (winner >= 0) begin
        m_pend = 1;
        m_cyc  = 1;
        m_id   = winner;
        ro     = gate_ref(req_in[4*winner +: 4]);
        m_o1   = ro[1];
        m_o2   = ro[0];
        m_ptr  = (winner + 1) % N;
      end else if (m_pend != 0) begin
        if (m_cyc >= 2) begin
          if (rsp_ready) m_pend = 0;
        end else begin
          m_cyc++;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
